// File: rtl/timer.sv
// 8-bit memory-mapped timer/counter with prescaler, compare match and
// overflow detection; emits a one-cycle irq pulse per enabled event.
module timer #(
  parameter logic [7:0] TIMER_ADDRESS = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic       irq
);

  logic [6:0] ctrl;
  logic [7:0] cmp;
  logic [7:0] cnt;
  logic       ovf;
  logic       mat;
  logic [7:0] pcnt;

  logic       en;
  logic [2:0] psel;
  logic       com;
  logic       oie;
  logic       mie;

  assign en   = ctrl[0];
  assign psel = ctrl[3:1];
  assign com  = ctrl[4];
  assign oie  = ctrl[5];
  assign mie  = ctrl[6];

  logic [7:0] off;
  logic       hit;

  assign off = address - TIMER_ADDRESS;
  assign hit = (off[7:2] == 6'd0);

  logic wr_ctrl;
  logic wr_cmp;
  logic wr_cnt;
  logic wr_stat;

  assign wr_ctrl = w_en && hit && (off[1:0] == 2'd0);
  assign wr_cmp  = w_en && hit && (off[1:0] == 2'd1);
  assign wr_cnt  = w_en && hit && (off[1:0] == 2'd2);
  assign wr_stat = w_en && hit && (off[1:0] == 2'd3);

  // 2^PSEL - 1 without a wide shift
  logic [7:0] limit;
  logic       tick;
  logic       ev;

  assign limit = 8'h7f >> (3'd7 - psel);
  assign tick  = en && (pcnt == limit);
  assign ev    = tick && !wr_cnt;

  logic match;
  logic clr;
  logic wrap;

  assign match = (cnt == cmp);
  assign clr   = match && com;
  assign wrap  = (cnt == 8'hff) && !clr;

  logic [7:0] rdata;

  always_comb begin
    rdata = 8'h00;
    unique case (off[1:0])
      2'd0: rdata = {1'b0, ctrl};
      2'd1: rdata = cmp;
      2'd2: rdata = cnt;
      2'd3: rdata = {6'd0, mat, ovf};
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl <= '0;
      cmp  <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      mat  <= 1'b0;
      pcnt <= '0;
      dout <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= din[6:0];
      if (wr_cmp)  cmp  <= din;

      if (wr_ctrl || wr_cnt || !en || tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + 8'd1;

      if (wr_cnt)
        cnt <= din;
      else if (ev)
        cnt <= clr ? 8'h00 : cnt + 8'd1;

      // a same-cycle event beats write-1-to-clear
      if (ev && wrap)
        ovf <= 1'b1;
      else if (wr_stat && din[0])
        ovf <= 1'b0;

      if (ev && match)
        mat <= 1'b1;
      else if (wr_stat && din[1])
        mat <= 1'b0;

      irq  <= ev && ((match && mie) || (wrap && oie));
      dout <= (r_en && hit) ? rdata : 8'h00;
    end
  end

endmodule
